pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Avalon-MM slave that measures an incoming PWM waveform, as the receive-side counterpart of the PWM generator.
- Synchronises pwm_in, detects its edges, and counts period and high time in prescaled ticks.
- Publishes each completed measurement as a coherent PERIOD/HIGH pair through CSRs.
- Sits on the same system bus as the PWM generator; used for loopback self-test and for external PWM/tach inputs.

Parameters:
- CNT_W, 16, width of the period/high counters and result registers (max 32).
- SYNC_STAGES, 2, flip-flop stages in the pwm_in synchroniser (min 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- chipselect  in  1  slave select.
- write  in  1  write strobe; qualified by chipselect.
- read  in  1  read strobe; qualified by chipselect.
- address  in  3  word address.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- pwm_in  in  1  asynchronous PWM input.

Behaviour:
- Register map (unused bits read 0):
  - 0 CTRL RW: bit0 enable; bit1 clear (write-1 pulse, reads 0).
  - 1 STATUS: bit0 valid (W1C); bit1 overflow (W1C); bit2 running (RO); bit3 synchronised level (RO).
  - 2 PERIOD RO. 3 HIGH RO. 4 PRESCALER RW, CNT_W bits. 5–7 read 0.
- Reset: all registers 0, readdata 0, state IDLE.
- readdata is updated on the clk edge where chipselect&read is high: one-cycle read latency. It holds its value otherwise.
- Writes take effect on the clk edge where chipselect&write is high.
- Input path: pwm_in → SYNC_STAGES flops → one edge flop. rise/fall are single-cycle pulses.
- Tick generation:
  - Tick when pre_cnt==PRESCALER; pre_cnt then wraps to 0.
  - pre_cnt is cleared on every rise.
  - PRESCALER=0 gives a tick every clk.
- FSM: IDLE → ARM → MEASURE.
  - IDLE: counters held at 0. Go to ARM when enable=1.
  - ARM: wait for rise. On rise: cnt<=1, go to MEASURE. A leading fall is ignored.
  - MEASURE, on rise: PERIOD<=cnt; HIGH<=high_shadow; valid<=1; cnt<=1; stay in MEASURE.
  - MEASURE, on fall: high_shadow<=cnt.
  - MEASURE, on tick with no edge: cnt<=cnt+1.
  - MEASURE, tick with cnt==2^CNT_W−1: overflow<=1, go to ARM; PERIOD/HIGH unchanged. Constant input (0%/100% duty) ends here.
- Count semantics:
  - PRESCALER=0: PERIOD equals the period in clks and HIGH equals the high time in clks, exactly.
  - PRESCALER=p: PERIOD = period/(p+1) when divisible.
- PERIOD and HIGH are always from the same cycle. A new result overwrites the old one even if valid is still set.
- enable→0 in any state: go to IDLE, clear cnt/high_shadow/pre_cnt. PERIOD, HIGH and STATUS are retained.
- PRESCALER write while enabled: go to ARM, clear counters.
- CTRL.clear: valid, overflow, PERIOD and HIGH → 0; go to ARM if enabled.
  - A simultaneous capture on the same cycle is discarded (clear wins).
- STATUS W1C on the same cycle as a set event: set wins.
- Reset asserted mid-measurement: immediate return to reset values.

Optional Feature:
- Macro: PWM_CAPTURE_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit).
  - Adds register 5 IRQ_MASK RW bits[1:0].
  - irq is registered: irq <= |(STATUS[1:0] & IRQ_MASK), reset 0.
- Undefined: no irq port; address 5 reads 0 and writes are ignored.

Decomposition:
- Package pwm_capture_pkg:
  - Register address constants (ADDR_CTRL … ADDR_IRQ_MASK).
  - CTRL/STATUS bit-position constants.
  - FSM state enum {IDLE, ARM, MEASURE}.
- One sub-module pwm_capture_sync_edge: synchroniser plus edge detector. Parameter SYNC_STAGES; outputs level, rise, fall.
- CSR decode, FSM and counters stay in the top module.

Test Plan:
- Reset, then read every address → all read 0; readdata appears one clk after read.
- PRESCALER=0, enable, pwm_in period 100 clks with high 25 → after the second rise: valid=1, PERIOD=100, HIGH=25.
- PRESCALER=3, period 40 with high 12 → PERIOD=10, HIGH=3.
- pwm_in held low after one rise, CNT_W=16, PRESCALER=0 → overflow=1 after 65535 ticks; PERIOD/HIGH unchanged; W1C STATUS=0x3 → STATUS bits[1:0]=0.
- Disable mid-period, then re-enable → the first rise only arms; the next complete period yields correct values with no stale count.
- With PWM_CAPTURE_IRQ_EN, IRQ_MASK=1 → irq rises one clk after valid sets; falls one clk after W1C of valid.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: register map, CSR bit positions and FSM states for pwm_capture
package pwm_capture_pkg;
    localparam logic [2:0] ADDR_CTRL      = 3'd0;
    localparam logic [2:0] ADDR_STATUS    = 3'd1;
    localparam logic [2:0] ADDR_PERIOD    = 3'd2;
    localparam logic [2:0] ADDR_HIGH      = 3'd3;
    localparam logic [2:0] ADDR_PRESCALER = 3'd4;
    localparam logic [2:0] ADDR_IRQ_MASK  = 3'd5;
    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_CLEAR  = 1;
    localparam int ST_VALID    = 0;
    localparam int ST_OVERFLOW = 1;
    localparam int ST_RUNNING  = 2;
    localparam int ST_LEVEL    = 3;
    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: Avalon-MM slave bus bundle (chipselect, write, read, address, writedata, readdata)
interface pwm_capture_if;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master(output chipselect, write, read, address, writedata, input readdata);
    modport slave(input chipselect, write, read, address, writedata, output readdata);
endinterface

// File: rtl/pwm_capture_sync_edge.sv
// pwm_capture_sync_edge: pwm_in synchroniser plus edge detector
// Ports: clk, reset (async, active-high), d (async input), level (synchronised),
//        rise/fall (single-cycle edge pulses)
module pwm_capture_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync;
    logic prev;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
            prev <= sync[SYNC_STAGES-1];
        end
    assign level = sync[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: Avalon-MM PWM receiver measuring period and high time in prescaled ticks
// Ports: clk, reset (async, active-high), bus (Avalon-MM slave, 1-cycle registered read),
//        pwm_in (async PWM input), irq (only when PWM_CAPTURE_IRQ_EN is defined:
//        registered |(STATUS[1:0] & IRQ_MASK); address 5 is IRQ_MASK, otherwise reads 0)
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    pwm_capture_if.slave bus,
    input  logic         pwm_in
`ifdef PWM_CAPTURE_IRQ_EN
    ,
    output logic         irq
`endif
);
    state_t state;
    logic enable, valid, overflow, level, rise, fall, tick;
    logic wr, rd, st_wr, clr, restart, capture, ovf_set, unused;
    logic [CNT_W-1:0] prescaler, pre_cnt, cnt, high_shadow, period, high;
    logic [31:0] rdata;
`ifdef PWM_CAPTURE_IRQ_EN
    logic [1:0] irq_mask;
`endif
    pwm_capture_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .reset(reset), .d(pwm_in), .level(level), .rise(rise), .fall(fall)
    );
    assign wr      = bus.chipselect & bus.write;
    assign rd      = bus.chipselect & bus.read;
    assign st_wr   = wr && bus.address == ADDR_STATUS;
    assign clr     = wr && bus.address == ADDR_CTRL && bus.writedata[CTRL_CLEAR];
    // a clear or a new prescale abandons any partial measurement
    assign restart = clr || (wr && bus.address == ADDR_PRESCALER);
    assign tick    = pre_cnt == prescaler;
    assign capture = enable && !restart && state == MEASURE && rise;
    assign ovf_set = enable && !restart && state == MEASURE && !rise && tick && cnt == '1;
    assign unused  = ^bus.writedata;
    always_comb begin
        rdata = '0;
        case (bus.address)
            ADDR_CTRL:      rdata[CTRL_ENABLE] = enable;
            ADDR_STATUS: begin
                rdata[ST_VALID]    = valid;
                rdata[ST_OVERFLOW] = overflow;
                rdata[ST_RUNNING]  = state == MEASURE;
                rdata[ST_LEVEL]    = level;
            end
            ADDR_PERIOD:    rdata[CNT_W-1:0] = period;
            ADDR_HIGH:      rdata[CNT_W-1:0] = high;
            ADDR_PRESCALER: rdata[CNT_W-1:0] = prescaler;
`ifdef PWM_CAPTURE_IRQ_EN
            ADDR_IRQ_MASK:  rdata[1:0] = irq_mask;
`endif
            default: ;
        endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            high_shadow <= '0;
            pre_cnt     <= '0;
        end else if (!enable || restart) begin
            state       <= enable ? ARM : IDLE;
            cnt         <= '0;
            high_shadow <= '0;
            pre_cnt     <= '0;
        end else begin
            // tick phase is realigned to every rise so whole periods divide evenly
            pre_cnt <= (rise || tick) ? '0 : pre_cnt + 1'b1;
            case (state)
                IDLE: state <= ARM;
                ARM: if (rise) begin
                    cnt   <= CNT_W'(1);
                    state <= MEASURE;
                end
                default: begin
                    if (rise)
                        cnt <= CNT_W'(1);
                    else if (tick && cnt == '1) begin
                        cnt   <= '0;
                        state <= ARM;
                    end else if (tick)
                        cnt <= cnt + 1'b1;
                    if (fall)
                        high_shadow <= cnt;
                end
            endcase
        end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            enable       <= 1'b0;
            prescaler    <= '0;
            period       <= '0;
            high         <= '0;
            valid        <= 1'b0;
            overflow     <= 1'b0;
            bus.readdata <= '0;
        end else begin
            if (wr && bus.address == ADDR_CTRL)
                enable <= bus.writedata[CTRL_ENABLE];
            if (wr && bus.address == ADDR_PRESCALER)
                prescaler <= bus.writedata[CNT_W-1:0];
            if (clr || capture) begin
                period <= clr ? '0 : cnt;
                high   <= clr ? '0 : high_shadow;
            end
            // a set event on the same edge beats its W1C
            valid    <= !clr && (capture || (valid && !(st_wr && bus.writedata[ST_VALID])));
            overflow <= !clr && (ovf_set || (overflow && !(st_wr && bus.writedata[ST_OVERFLOW])));
            if (rd)
                bus.readdata <= rdata;
        end
`ifdef PWM_CAPTURE_IRQ_EN
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr && bus.address == ADDR_IRQ_MASK)
                irq_mask <= bus.writedata[1:0];
            irq <= |({overflow, valid} & irq_mask);
        end
`endif
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: self-checking bench for pwm_capture (register table plus PWM corner sequences)
module tb_pwm_capture;
    import pwm_capture_pkg::*;
    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] data;
        string       name;
    } vec_t;
    typedef struct {
        logic [31:0] exp;
        logic [31:0] mask;
        string       name;
    } exp_t;
`ifdef PWM_CAPTURE_IRQ_EN
    localparam logic [31:0] IRQ_RB = 32'h3;
`else
    localparam logic [31:0] IRQ_RB = 32'h0;
`endif
    logic clk = 1'b0, reset = 1'b1, pwm_in = 1'b0, rd_q = 1'b0, irq;
    int checks = 0, failures = 0;
    exp_t sb[$];
    vec_t vecs[24];
    pwm_capture_if bus();
    pwm_capture dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .pwm_in(pwm_in)
`ifdef PWM_CAPTURE_IRQ_EN
        ,
        .irq(irq)
`endif
    );
`ifndef PWM_CAPTURE_IRQ_EN
    assign irq = 1'b0;
`endif
    always #5 clk = ~clk;
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", name, act, exp);
        end
    endtask
    always @(posedge clk) rd_q <= bus.chipselect & bus.read;
    always @(negedge clk) begin
        exp_t e;
        if (rd_q) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_read got=0x%08h", bus.readdata);
            end else begin
                e = sb.pop_front();
                check(e.name, bus.readdata & e.mask, e.exp);
            end
        end
    end
    task automatic bus_write(logic [2:0] a, logic [31:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write = 1'b0;
    endtask
    task automatic bus_read(logic [2:0] a, logic [31:0] e, logic [31:0] m, string n);
        @(negedge clk);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
        sb.push_back('{e & m, m, n});
        @(negedge clk);
        bus.chipselect = 1'b0; bus.read = 1'b0;
    endtask
    task automatic pwm_cycles(int period, int high, int n);
        repeat (n) begin
            pwm_in = 1'b1;
            repeat (high) @(negedge clk);
            pwm_in = 1'b0;
            repeat (period - high) @(negedge clk);
        end
    endtask
    initial begin
        bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
        bus.address = '0; bus.writedata = '0;
        vecs = '{
            '{1'b0, 3'd0, 32'h0, "rst_ctrl"},
            '{1'b0, 3'd1, 32'h0, "rst_status"},
            '{1'b0, 3'd2, 32'h0, "rst_period"},
            '{1'b0, 3'd3, 32'h0, "rst_high"},
            '{1'b0, 3'd4, 32'h0, "rst_prescaler"},
            '{1'b0, 3'd5, 32'h0, "rst_addr5"},
            '{1'b0, 3'd6, 32'h0, "rst_addr6"},
            '{1'b0, 3'd7, 32'h0, "rst_addr7"},
            '{1'b1, ADDR_PRESCALER, 32'h0001_2345, "w_presc"},
            '{1'b0, ADDR_PRESCALER, 32'h0000_2345, "presc_trunc"},
            '{1'b1, 3'd5, 32'hFFFF_FFFF, "w_addr5"},
            '{1'b0, 3'd5, IRQ_RB, "addr5_rb"},
            '{1'b1, 3'd6, 32'hFFFF_FFFF, "w_addr6"},
            '{1'b0, 3'd6, 32'h0, "addr6_rb"},
            '{1'b1, 3'd7, 32'hFFFF_FFFF, "w_addr7"},
            '{1'b0, 3'd7, 32'h0, "addr7_rb"},
            '{1'b1, ADDR_CTRL, 32'h2, "w_ctrl_clr"},
            '{1'b0, ADDR_CTRL, 32'h0, "ctrl_clr_reads0"},
            '{1'b1, ADDR_CTRL, 32'h3, "w_ctrl_en_clr"},
            '{1'b0, ADDR_CTRL, 32'h1, "ctrl_en_rb"},
            '{1'b1, ADDR_CTRL, 32'h0, "w_ctrl_off"},
            '{1'b1, 3'd5, 32'h0, "w_addr5_off"},
            '{1'b1, ADDR_PRESCALER, 32'h0, "w_presc0"},
            '{1'b0, ADDR_PRESCALER, 32'h0, "presc0_rb"}
        };
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        for (int i = 0; i < 24; i++)
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
            else bus_read(vecs[i].addr, vecs[i].data, 32'hFFFF_FFFF, vecs[i].name);
        // one-cycle read latency, then hold
        bus_write(ADDR_PRESCALER, 32'h7);
        @(negedge clk);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = ADDR_PRESCALER;
        sb.push_back('{32'h7, 32'hFFFF_FFFF, "rd_latency"});
        check("rd_before_edge", bus.readdata, 32'h0);
        @(negedge clk);
        bus.chipselect = 1'b0; bus.read = 1'b0;
        @(negedge clk);
        check("rd_hold", bus.readdata, 32'h7);
        bus_write(ADDR_PRESCALER, 32'h0);
        // prescaler 0: exact clock counts
        bus_write(ADDR_CTRL, 32'h1);
        repeat (2) @(negedge clk);
        pwm_cycles(100, 25, 2);
        bus_read(ADDR_STATUS, 32'h1, 32'h3, "p0_status");
        bus_read(ADDR_PERIOD, 32'd100, 32'hFFFF_FFFF, "p0_period");
        bus_read(ADDR_HIGH, 32'd25, 32'hFFFF_FFFF, "p0_high");
        // prescaler 3
        bus_write(ADDR_PRESCALER, 32'h3);
        bus_write(ADDR_STATUS, 32'h1);
        bus_read(ADDR_STATUS, 32'h0, 32'h1, "valid_w1c");
        pwm_cycles(40, 12, 2);
        bus_read(ADDR_STATUS, 32'h1, 32'h3, "p3_status");
        bus_read(ADDR_PERIOD, 32'd10, 32'hFFFF_FFFF, "p3_period");
        bus_read(ADDR_HIGH, 32'd3, 32'hFFFF_FFFF, "p3_high");
        // clear, disable mid-period, re-enable
        bus_write(ADDR_PRESCALER, 32'h0);
        bus_write(ADDR_CTRL, 32'h3);
        bus_read(ADDR_PERIOD, 32'h0, 32'hFFFF_FFFF, "clr_period");
        bus_read(ADDR_STATUS, 32'h0, 32'h3, "clr_status");
        pwm_cycles(30, 10, 1);
        bus_write(ADDR_CTRL, 32'h0);
        repeat (5) @(negedge clk);
        bus_write(ADDR_CTRL, 32'h1);
        pwm_cycles(50, 15, 1);
        bus_read(ADDR_STATUS, 32'h0, 32'h1, "reen_arm_only");
        pwm_cycles(50, 15, 2);
        bus_read(ADDR_STATUS, 32'h1, 32'h1, "reen_status");
        bus_read(ADDR_PERIOD, 32'd50, 32'hFFFF_FFFF, "reen_period");
        bus_read(ADDR_HIGH, 32'd15, 32'hFFFF_FFFF, "reen_high");
        // overflow with input held low after one rise
        bus_write(ADDR_PRESCALER, 32'h0);
        bus_write(ADDR_STATUS, 32'h1);
        pwm_in = 1'b1;
        repeat (5) @(negedge clk);
        pwm_in = 1'b0;
        repeat (65400) @(negedge clk);
        bus_read(ADDR_STATUS, 32'h0, 32'h3, "ovf_not_yet");
        repeat (200) @(negedge clk);
        bus_read(ADDR_STATUS, 32'h2, 32'h3, "ovf_status");
        bus_read(ADDR_PERIOD, 32'd50, 32'hFFFF_FFFF, "ovf_period_kept");
        bus_read(ADDR_HIGH, 32'd15, 32'hFFFF_FFFF, "ovf_high_kept");
        bus_write(ADDR_STATUS, 32'h3);
        bus_read(ADDR_STATUS, 32'h0, 32'h3, "ovf_w1c");
`ifdef PWM_CAPTURE_IRQ_EN
        bus_write(ADDR_IRQ_MASK, 32'h1);
        pwm_cycles(30, 10, 1);
        check("irq_idle", {31'h0, irq}, 32'h0);
        pwm_in = 1'b1;
        repeat (3) @(negedge clk);
        check("irq_same_cycle_as_valid", {31'h0, irq}, 32'h0);
        @(negedge clk);
        check("irq_set", {31'h0, irq}, 32'h1);
        bus_write(ADDR_STATUS, 32'h1);
        check("irq_w1c_edge", {31'h0, irq}, 32'h1);
        @(negedge clk);
        check("irq_cleared", {31'h0, irq}, 32'h0);
`endif
        repeat (4) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL pending_reads got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
